// File: rtl/spi_share_pkg.sv
// Shared types and constants for the two-requester SPI byte engine.
package spi_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int PHASES  = 16;
    localparam int PHASE_W = $clog2(PHASES);
    localparam int NUM_REQ = 2;

endpackage

// File: rtl/spi_share_if.sv
// Requester-side bus of spi_share_ctrl: divider, two request/hold/data channels, acks and busy.
interface spi_share_if;

    logic [7:0] divisor;
    logic       req0;
    logic       req1;
    logic       hold0;
    logic       hold1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] q0;
    logic [7:0] q1;
    logic       ack0;
    logic       ack1;
    logic       busy;

    modport slave (
        input  divisor, req0, req1, hold0, hold1, d0, d1,
        output q0, q1, ack0, ack1, busy
    );

    modport master (
        output divisor, req0, req1, hold0, hold1, d0, d1,
        input  q0, q1, ack0, ack1, busy
    );

endinterface

// File: rtl/spi_share_shifter.sv
// SPI mode-0 byte shifter: 16 half-period phases of (div+1) clocks, MSB first.
// A single register shifts the transmit byte out of its top and miso into its bottom.
module spi_share_shifter
    import spi_share_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] div,
    input  logic [7:0] din,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] dout,
    output logic       done
);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASES - 1);

    logic               active_q;
    logic               sclk_q;
    logic               mosi_q;
    logic [PHASE_W-1:0] phase_q;
    logic [7:0]         cnt_q;
    logic [7:0]         div_q;
    logic [7:0]         sr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b1;
            phase_q  <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            div_q    <= div;
            sr_q     <= din;
            mosi_q   <= din[7];
            sclk_q   <= 1'b0;
            phase_q  <= '0;
            cnt_q    <= '0;
        end else if (active_q) begin
            if (cnt_q == div_q) begin
                cnt_q <= '0;
                if (phase_q == PHASE_LAST) begin
                    active_q <= 1'b0;
                    sclk_q   <= 1'b0;
                    mosi_q   <= 1'b1;
                end else begin
                    phase_q <= phase_q + 1'b1;
                    // Even phase ending means a rising edge: the bit on mosi leaves, miso enters.
                    if (!phase_q[0]) begin
                        sclk_q <= 1'b1;
                        sr_q   <= {sr_q[6:0], miso};
                    end else begin
                        sclk_q <= 1'b0;
                        mosi_q <= sr_q[7];
                    end
                end
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign dout = sr_q;
    assign done = active_q && (phase_q == PHASE_LAST) && (cnt_q == div_q);

endmodule

// File: rtl/spi_share_ctrl.sv
// Arbitrated SPI byte engine sharing one SD-card port between the CPU (0) and the boot loader (1).
// Define SPI_SHARE_LOCK_TIMEOUT_EN to force-release an idle lock after LOCK_TIMEOUT cycles.
module spi_share_ctrl
    import spi_share_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    spi_share_if.slave  bus,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs
);

    state_t             state_q;
    logic               lock_q;
    logic               last_q;
    logic               gnt_q;
    logic               cs_q;
    logic               ack0_q;
    logic               ack1_q;
    logic [7:0]         q0_q;
    logic [7:0]         q1_q;

    logic [NUM_REQ-1:0] req_v;
    logic [NUM_REQ-1:0] hold_v;
    logic               start_d;
    logic               pick_d;
    logic [7:0]         din_d;
    logic [7:0]         sh_dout;
    logic               sh_done;

`ifdef SPI_SHARE_LOCK_TIMEOUT_EN
    logic [31:0]        lock_cnt_q;
`else
    logic [31:0]        unused_lock_timeout;
    assign unused_lock_timeout = LOCK_TIMEOUT;
`endif

    assign req_v  = {bus.req1, bus.req0};
    assign hold_v = {bus.hold1, bus.hold0};
    assign din_d  = pick_d ? bus.d1 : bus.d0;

    // A held lock hides the other requester; otherwise a tie goes to whoever was not served last.
    always_comb begin
        start_d = 1'b0;
        pick_d  = gnt_q;
        if (state_q == IDLE) begin
            if (lock_q) begin
                start_d = req_v[gnt_q];
            end else if (&req_v) begin
                start_d = 1'b1;
                pick_d  = ~last_q;
            end else if (req_v[0]) begin
                start_d = 1'b1;
                pick_d  = 1'b0;
            end else if (req_v[1]) begin
                start_d = 1'b1;
                pick_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            cs_q    <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            q0_q    <= '0;
            q1_q    <= '0;
`ifdef SPI_SHARE_LOCK_TIMEOUT_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        state_q <= SHIFT;
                        gnt_q   <= pick_d;
                        last_q  <= pick_d;
                        cs_q    <= 1'b0;
`ifdef SPI_SHARE_LOCK_TIMEOUT_EN
                        lock_cnt_q <= '0;
`endif
                    end else if (lock_q && !hold_v[gnt_q]) begin
                        lock_q <= 1'b0;
                        cs_q   <= 1'b1;
                    end
`ifdef SPI_SHARE_LOCK_TIMEOUT_EN
                    else if (lock_q) begin
                        if (lock_cnt_q >= (LOCK_TIMEOUT - 32'd1)) begin
                            lock_q <= 1'b0;
                            cs_q   <= 1'b1;
                        end else begin
                            lock_cnt_q <= lock_cnt_q + 32'd1;
                        end
                    end
`endif
                end
                SHIFT: begin
                    if (sh_done) begin
                        state_q <= DONE;
                        if (gnt_q) begin
                            ack1_q <= 1'b1;
                            q1_q   <= sh_dout;
                        end else begin
                            ack0_q <= 1'b1;
                            q0_q   <= sh_dout;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (hold_v[gnt_q]) begin
                        lock_q <= 1'b1;
                    end else begin
                        lock_q <= 1'b0;
                        cs_q   <= 1'b1;
                    end
`ifdef SPI_SHARE_LOCK_TIMEOUT_EN
                    // The ack cycle counts as the first idle cycle of the holder.
                    lock_cnt_q <= 32'd1;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    spi_share_shifter u_shifter (
        .clk   (clk),
        .reset (reset),
        .start (start_d),
        .div   (bus.divisor),
        .din   (din_d),
        .miso  (spi_miso),
        .sclk  (spi_clk),
        .mosi  (spi_mosi),
        .dout  (sh_dout),
        .done  (sh_done)
    );

    assign spi_cs   = cs_q;
    assign bus.ack0 = ack0_q;
    assign bus.ack1 = ack1_q;
    assign bus.q0   = q0_q;
    assign bus.q1   = q1_q;
    assign bus.busy = (state_q != IDLE) || lock_q;

endmodule
